// File: rtl/avm_pkg.sv
// Shared types and sizing helpers for the Avalon-MM command master slice.
package avm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2
    } state_t;

    localparam int C_DEF_ADDR_W = 16;
    localparam int C_DEF_DATA_W = 32;
    localparam int C_DEF_TMO_W  = 8;
    localparam int C_DEF_BE_W   = C_DEF_DATA_W / 8;

    function automatic int be_width(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/avm_tmo_cnt.sv
// Saturating waitrequest stall counter; hit flags the last permitted stall cycle.
module avm_tmo_cnt #(
    parameter int C_TMO_W = 8
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               clr,
    input  logic               en,
    input  logic [C_TMO_W-1:0] tmo_limit,
    output logic               hit
);

    localparam logic [C_TMO_W-1:0] C_ONE = {{(C_TMO_W-1){1'b0}}, 1'b1};

    logic [C_TMO_W-1:0] cnt;

    // Holds at all-ones so a disabled timeout can never wrap into a false hit.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + C_ONE;
        end
    end

    assign hit = (tmo_limit != '0) && (cnt == (tmo_limit - C_ONE));

endmodule

// File: rtl/avm_cmd_master.sv
// Avalon-MM initiator: one single-beat bus transfer and one response per command,
// with a programmable waitrequest timeout.
module avm_cmd_master
    import avm_pkg::*;
#(
    parameter int C_ADDR_W = C_DEF_ADDR_W,
    parameter int C_DATA_W = C_DEF_DATA_W,
    parameter int C_TMO_W  = C_DEF_TMO_W,
    parameter int C_BE_W   = be_width(C_DATA_W)
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [C_ADDR_W-1:0] cmd_addr,
    input  logic [C_DATA_W-1:0] cmd_wdata,
    input  logic [C_BE_W-1:0]   cmd_be,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [C_DATA_W-1:0] rsp_rdata,
    output logic                rsp_err,
    input  logic [C_TMO_W-1:0]  tmo_limit,
    output logic [C_ADDR_W-1:0] avm_address,
    output logic                avm_read,
    output logic                avm_write,
    output logic [C_DATA_W-1:0] avm_writedata,
    output logic [C_BE_W-1:0]   avm_byteenable,
    input  logic [C_DATA_W-1:0] avm_readdata,
    input  logic                avm_waitrequest
);

    state_t state;
    logic   accept;
    logic   tmo_hit;

    assign accept = (state == ST_IDLE) && cmd_valid && cmd_ready;

    avm_tmo_cnt #(
        .C_TMO_W (C_TMO_W)
    ) u_tmo_cnt (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .clr       (accept),
        .en        ((state == ST_REQ) && avm_waitrequest),
        .tmo_limit (tmo_limit),
        .hit       (tmo_hit)
    );

    // cmd_ready is registered, so it comes up one edge after reset release.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state          <= ST_IDLE;
            cmd_ready      <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_rdata      <= '0;
            rsp_err        <= 1'b0;
            avm_address    <= '0;
            avm_read       <= 1'b0;
            avm_write      <= 1'b0;
            avm_writedata  <= '0;
            avm_byteenable <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        avm_address    <= cmd_addr;
                        avm_writedata  <= cmd_wdata;
                        avm_byteenable <= cmd_be;
                        avm_read       <= ~cmd_write;
                        avm_write      <= cmd_write;
                        cmd_ready      <= 1'b0;
                        state          <= ST_REQ;
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                ST_REQ: begin
                    // A completing slave wins over a timeout hitting on the same edge.
                    if (!avm_waitrequest) begin
                        avm_read  <= 1'b0;
                        avm_write <= 1'b0;
                        rsp_rdata <= avm_read ? avm_readdata : '0;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= ST_RSP;
                    end else if (tmo_hit) begin
                        avm_read  <= 1'b0;
                        avm_write <= 1'b0;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_avm_cmd_master.sv
// Self-checking bench for avm_cmd_master: directed table, random transfers
// against a rule-level model, and hand-written reset/stall sequences.
module tb_avm_cmd_master;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [15:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_be = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [7:0]  tmo_limit = '0;
    logic [15:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_readdata = '0;
    logic        avm_waitrequest = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 sys_clk = ~sys_clk;

    avm_cmd_master dut (
        .sys_clk         (sys_clk),
        .sys_rst         (sys_rst),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_write       (cmd_write),
        .cmd_addr        (cmd_addr),
        .cmd_wdata       (cmd_wdata),
        .cmd_be          (cmd_be),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_rdata       (rsp_rdata),
        .rsp_err         (rsp_err),
        .tmo_limit       (tmo_limit),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_byteenable  (avm_byteenable),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest)
    );

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          stall;
        logic [7:0]  tmo;
        logic [31:0] slave_rd;
        int          rsp_delay;
        int          exp_cycles;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    // Rule-level expectation: the slave stalls for `stall` cycles; a nonzero
    // limit allows at most `tmo` strobe cycles before the transfer is aborted.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        if (v.tmo != 0 && v.stall >= int'(v.tmo)) begin
            r.exp_cycles = int'(v.tmo);
            r.exp_err    = 1'b1;
            r.exp_rdata  = 32'h0;
        end else begin
            r.exp_cycles = v.stall + 1;
            r.exp_err    = 1'b0;
            r.exp_rdata  = v.wr ? 32'h0 : v.slave_rd;
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        int   waited;
        int   cycles;
        logic strobe;
        @(negedge sys_clk);
        waited = 0;
        while (!cmd_ready && waited < 20) begin
            @(negedge sys_clk);
            waited++;
        end
        checkOutput("cmd_ready_idle", {31'b0, cmd_ready}, 32'd1);
        if (!cmd_ready) return;

        cmd_valid       = 1'b1;
        cmd_write       = v.wr;
        cmd_addr        = v.addr;
        cmd_wdata       = v.wdata;
        cmd_be          = v.be;
        tmo_limit       = v.tmo;
        avm_waitrequest = (v.stall > 0);
        avm_readdata    = avm_waitrequest ? $urandom : v.slave_rd;
        @(posedge sys_clk);
        #1;
        cmd_valid = 1'b0;
        cmd_addr  = 16'($urandom);
        cmd_wdata = $urandom;

        cycles = 0;
        @(negedge sys_clk);
        strobe = v.wr ? avm_write : avm_read;
        while (strobe && cycles < 700) begin
            checkOutput("avm_address", {16'b0, avm_address}, {16'b0, v.addr});
            checkOutput("avm_byteenable", {28'b0, avm_byteenable}, {28'b0, v.be});
            checkOutput("other_strobe", {31'b0, v.wr ? avm_read : avm_write}, 32'd0);
            if (v.wr) checkOutput("avm_writedata", avm_writedata, v.wdata);
            cycles++;
            @(posedge sys_clk);
            #1;
            avm_waitrequest = (cycles < v.stall);
            avm_readdata    = avm_waitrequest ? $urandom : v.slave_rd;
            @(negedge sys_clk);
            strobe = v.wr ? avm_write : avm_read;
        end
        avm_waitrequest = 1'b1;

        checkOutput("strobe_cycles", cycles, v.exp_cycles);
        checkOutput("rsp_valid", {31'b0, rsp_valid}, 32'd1);
        checkOutput("rsp_err", {31'b0, rsp_err}, {31'b0, v.exp_err});
        checkOutput("rsp_rdata", rsp_rdata, v.exp_rdata);
        checkOutput("strobes_low_rsp", {30'b0, avm_read, avm_write}, 32'd0);

        // Back-pressure with a competing command offered: nothing may move.
        cmd_valid = 1'b1;
        cmd_write = ~v.wr;
        rsp_ready = 1'b0;
        for (int i = 0; i < v.rsp_delay; i++) begin
            @(negedge sys_clk);
            checkOutput("bp_rsp_valid", {31'b0, rsp_valid}, 32'd1);
            checkOutput("bp_rsp_err", {31'b0, rsp_err}, {31'b0, v.exp_err});
            checkOutput("bp_rsp_rdata", rsp_rdata, v.exp_rdata);
            checkOutput("bp_cmd_ready", {31'b0, cmd_ready}, 32'd0);
            checkOutput("bp_strobes", {30'b0, avm_read, avm_write}, 32'd0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge sys_clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge sys_clk);
        checkOutput("rsp_valid_drop", {31'b0, rsp_valid}, 32'd0);
        checkOutput("cmd_ready_back", {31'b0, cmd_ready}, 32'd1);
        checkOutput("strobes_low_idle", {30'b0, avm_read, avm_write}, 32'd0);
    endtask

    vec_t tbl[9];
    vec_t rv;

    initial begin
        // wr addr wdata be stall tmo slave_rd rsp_delay | cycles err rdata
        tbl[0] = '{1'b0, 16'h0010, 32'h0,        4'hF, 2,   8'd0, 32'hDEADBEEF, 0, 3,   1'b0, 32'hDEADBEEF};
        tbl[1] = '{1'b1, 16'h0004, 32'h12345678, 4'h3, 0,   8'd0, 32'hFFFFFFFF, 0, 1,   1'b0, 32'h0};
        tbl[2] = '{1'b0, 16'h0020, 32'h0,        4'hF, 50,  8'd4, 32'h11111111, 0, 4,   1'b1, 32'h0};
        tbl[3] = '{1'b0, 16'h0030, 32'h0,        4'hC, 2,   8'd3, 32'hCAFEF00D, 0, 3,   1'b0, 32'hCAFEF00D};
        tbl[4] = '{1'b0, 16'h0040, 32'h0,        4'h1, 1,   8'd0, 32'h01234567, 5, 2,   1'b0, 32'h01234567};
        tbl[5] = '{1'b1, 16'h0050, 32'hA5A5A5A5, 4'h8, 5,   8'd1, 32'h0,        0, 1,   1'b1, 32'h0};
        tbl[6] = '{1'b1, 16'h0060, 32'h5A5A5A5A, 4'hF, 5,   8'd5, 32'h0,        2, 5,   1'b1, 32'h0};
        tbl[7] = '{1'b1, 16'h0070, 32'h87654321, 4'h6, 5,   8'd6, 32'h0,        1, 6,   1'b0, 32'h0};
        tbl[8] = '{1'b0, 16'h0080, 32'h0,        4'hF, 300, 8'd0, 32'h600DF00D, 0, 301, 1'b0, 32'h600DF00D};

        @(negedge sys_clk);
        checkOutput("reset_flags", {27'b0, cmd_ready, rsp_valid, rsp_err, avm_read, avm_write}, 32'd0);
        checkOutput("reset_rsp_rdata", rsp_rdata, 32'd0);
        checkOutput("reset_avm_address", {16'b0, avm_address}, 32'd0);
        checkOutput("reset_avm_writedata", avm_writedata, 32'd0);
        checkOutput("reset_avm_byteenable", {28'b0, avm_byteenable}, 32'd0);
        #2 sys_rst = 1'b0;

        for (int i = 0; i < 9; i++) applyStimulus(tbl[i]);

        for (int i = 0; i < 40; i++) begin
            rv.wr        = 1'($urandom_range(0, 1));
            rv.addr      = 16'($urandom);
            rv.wdata     = $urandom;
            rv.be        = 4'($urandom);
            rv.stall     = $urandom_range(0, 6);
            rv.tmo       = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 7));
            rv.slave_rd  = $urandom;
            rv.rsp_delay = $urandom_range(0, 3);
            applyStimulus(model(rv));
        end

        // Reset during a stalled read must drop the strobe without a clock.
        @(negedge sys_clk);
        cmd_valid       = 1'b1;
        cmd_write       = 1'b0;
        cmd_addr        = 16'h0099;
        tmo_limit       = 8'd0;
        avm_waitrequest = 1'b1;
        @(posedge sys_clk);
        #1 cmd_valid = 1'b0;
        repeat (3) @(negedge sys_clk);
        checkOutput("stalled_read_high", {31'b0, avm_read}, 32'd1);
        #2 sys_rst = 1'b1;
        #1;
        checkOutput("async_rst_strobes", {30'b0, avm_read, avm_write}, 32'd0);
        checkOutput("async_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        @(negedge sys_clk);
        #2 sys_rst = 1'b0;
        avm_waitrequest = 1'b0;
        repeat (4) begin
            @(negedge sys_clk);
            checkOutput("no_rsp_after_rst", {31'b0, rsp_valid}, 32'd0);
        end
        applyStimulus(tbl[0]);
        applyStimulus(tbl[1]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/avm_cmd_master.md
Name: avm_cmd_master

Overview:
- Avalon-MM master (initiator) that turns single-beat read/write commands from local logic into bus transfers.
- Honours avs-side waitrequest and captures read data.
- Returns one response per command.
- A programmable waitrequest timeout aborts stalled transfers and flags an error.
- Sits between control/sequencer logic and the register-slave fabric; it is the initiating end of the waitrequest-timed register interface.

Parameters:
C_ADDR_W, 16, address width in bits.
C_DATA_W, 32, data width in bits; multiple of 8.
C_TMO_W, 8, width of timeout counter and of the tmo_limit input.

Ports:
sys_clk  in  1  clock; all logic rising-edge.
sys_rst  in  1  asynchronous active-high reset.
cmd_valid  in  1  command offered.
cmd_ready  out  1  master can accept a command.
cmd_write  in  1  1=write, 0=read.
cmd_addr  in  C_ADDR_W  target address.
cmd_wdata  in  C_DATA_W  write data.
cmd_be  in  C_DATA_W/8  byte enables.
rsp_valid  out  1  response available.
rsp_ready  in  1  consumer accepts response.
rsp_rdata  out  C_DATA_W  read data; 0 for writes and errors.
rsp_err  out  1  transfer aborted by timeout.
tmo_limit  in  C_TMO_W  max waitrequest-high cycles; 0 disables timeout.
avm_address  out  C_ADDR_W  bus address.
avm_read  out  1  bus read strobe.
avm_write  out  1  bus write strobe.
avm_writedata  out  C_DATA_W  bus write data.
avm_byteenable  out  C_DATA_W/8  bus byte enables.
avm_readdata  in  C_DATA_W  bus read data, valid when avm_read=1 and avm_waitrequest=0.
avm_waitrequest  in  1  slave stall.

Behaviour:
- Reset (async, sys_rst=1): state IDLE.
  - All outputs 0: cmd_ready, rsp_valid, rsp_err, rsp_rdata, avm_read, avm_write, avm_address, avm_writedata, avm_byteenable.
  - Timeout counter 0.
  - Reset mid-transfer drops strobes immediately (asynchronously); no response is produced for the interrupted command.
- States:
  - IDLE: cmd_ready=1. On cmd_valid, at the clock edge: register addr/wdata/be/write onto the avm_* outputs, assert avm_read or avm_write, clear counter, go REQ.
  - REQ: cmd_ready=0. Strobe, address, data and be held stable every cycle.
    - On a clock edge with avm_waitrequest=0, the transfer completes:
      - drop strobe;
      - rsp_rdata <= avm_readdata for reads, 0 for writes;
      - rsp_err <= 0;
      - go RSP.
    - Otherwise the counter increments.
    - If tmo_limit!=0 and the counter equals tmo_limit-1 at an edge with waitrequest=1: drop strobe, rsp_err <= 1, rsp_rdata <= 0, go RSP.
    - Completion takes priority over timeout on the same edge.
  - RSP: rsp_valid=1; response held stable until rsp_ready=1 at an edge, then go IDLE.
- Latency:
  - Command accept edge to first strobe cycle: 0 (strobe asserted from the accept edge).
  - Strobe is high for exactly N+1 cycles when the slave holds waitrequest for N cycles.
  - rsp_valid rises the cycle after completion.
  - Minimum command-to-command spacing is 3 cycles, because cmd_ready is low through REQ and RSP. Intended: it guarantees a slave sees strobe low for at least one cycle between transfers.
- avm_read and avm_write are never high simultaneously. Strobes are low in IDLE and RSP.
- tmo_limit is sampled continuously. Changing it during REQ takes effect on the next compare.
- The counter saturates at all-ones and does not wrap. If tmo_limit=0, a stall is waited out indefinitely.
- cmd_* inputs are ignored outside IDLE. rsp_ready is ignored outside RSP.
- Address, data and be outputs retain their last values in IDLE/RSP (don't-care for the slave).

Decomposition:
- Shared package avm_pkg:
  - state encoding typedef (IDLE, REQ, RSP);
  - localparams for byte-enable width (C_DATA_W/8).
- One sub-module: avm_tmo_cnt, a saturating counter with clear/enable and a compare-equal output against tmo_limit-1, gated by tmo_limit!=0.
- The FSM and datapath registers stay in avm_cmd_master.

Test Plan:
- Read, slave stalls 2 cycles. Command: cmd_addr=0x0010, slave returns 0xDEADBEEF. Required: avm_read high 3 cycles with avm_address=0x0010; rsp_rdata=0xDEADBEEF and rsp_err=0 one cycle later; cmd_ready back to 1 after rsp_ready.
- Write, zero-wait slave. Command: cmd_addr=0x0004, cmd_wdata=0x12345678, cmd_be=4'b0011. Required: avm_write high exactly 1 cycle with matching data and be; response rsp_rdata=0, rsp_err=0.
- Timeout. tmo_limit=4, waitrequest stuck at 1. Required: avm_read high exactly 4 cycles then low; rsp_err=1, rsp_rdata=0. With tmo_limit=0, the strobe is still held after 300 cycles.
- Race: waitrequest falls on the same edge the counter reaches tmo_limit-1 (tmo_limit=3, 2-cycle stall). Required: rsp_err=0 and valid read data.
- Back-pressure: hold rsp_ready=0 for 5 cycles with cmd_valid=1. Required: rsp_valid, rsp_rdata and rsp_err stable; cmd_ready=0; no second strobe until rsp_ready=1.
- Reset mid-REQ. Assert sys_rst during a stalled read. Required: avm_read=0 in the same cycle without waiting for a clock; no rsp_valid after release; the next command executes normally.
